// File: rtl/ctrl_pkg.sv
// Shared controller definitions: opcode encodings and the three-cycle slot phases.
// Used by the instruction queue and by the downstream controller.
package ctrl_pkg;

  localparam logic [2:0] OP_FETCH = 3'h0;
  localparam logic [2:0] OP_WRITE = 3'h1;
  localparam logic [2:0] OP_ADD   = 3'h2;
  localparam logic [2:0] OP_SUB   = 3'h3;
  localparam logic [2:0] OP_MULT  = 3'h4;
  localparam logic [2:0] OP_DIV   = 3'h5;
  localparam logic [2:0] OP_SHIFT = 3'h6;
  localparam logic [2:0] OP_NOP   = 3'h7;

  localparam logic [1:0] PH_WAITE = 2'd0;
  localparam logic [1:0] PH_LOAD  = 2'd1;
  localparam logic [1:0] PH_STORE = 2'd2;

  // Phase 3 is unreachable; it recovers to WAITE rather than locking up.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_WAITE: nxt = PH_LOAD;
      PH_LOAD:  nxt = PH_STORE;
      PH_STORE: nxt = PH_WAITE;
      default:  nxt = PH_WAITE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Opcode FIFO: storage, wrapping pointers and occupancy count.
// The caller guarantees push only when not full (or with a same-edge pop) and pop only when not empty.
module instr_fifo
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [2:0]               din,
  output logic [2:0]               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [2:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Storage, pointer and count update; clear empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= OP_NOP;
      end
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue: buffers upstream opcodes and presents one per three-cycle slot,
// filling empty slots with NOP and flagging queued entries with instr_valid.
module instruction_queue
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [2:0]               instruction,
  output logic                     instr_valid,
  output logic [1:0]               phase,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic [1:0]    phase_r;
  logic [2:0]    instruction_r;
  logic          instr_valid_r;
  logic [2:0]    head_s;
  logic [CW-1:0] count_s;
  logic          boundary_s;
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;

  // Handshake and slot-boundary decode; a full queue still accepts on the pop edge.
  always_comb begin
    boundary_s = (phase_r == PH_STORE);
    in_ready_s = !flush && ((count_s < DEPTH_C) || boundary_s);
    push_s     = in_valid && in_ready_s;
    pop_s      = boundary_s && !flush && (count_s != ZERO_C);
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .clear (flush),
    .din   (in_instr),
    .head  (head_s),
    .count (count_s)
  );

  // Free-running slot phase; flush never disturbs it.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r <= PH_WAITE;
    end else begin
      phase_r <= next_phase(phase_r);
    end
  end

  // Presented opcode changes only at the slot boundary; the pop is seen before any same-edge push.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_r <= OP_NOP;
      instr_valid_r <= 1'b0;
    end else if (boundary_s) begin
      if (pop_s) begin
        instruction_r <= head_s;
        instr_valid_r <= 1'b1;
      end else begin
        instruction_r <= OP_NOP;
        instr_valid_r <= 1'b0;
      end
    end else begin
      instruction_r <= instruction_r;
      instr_valid_r <= instr_valid_r;
    end
  end

  assign in_ready    = in_ready_s;
  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign phase       = phase_r;
  assign count       = count_s;

endmodule
